// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix-multiply engine: C = A * B, streamed as K column/row vector pairs.
// Optional SYSTOLIC_MM_SATURATE_EN clamps each accumulate instead of wrapping.
module systolic_mm_engine #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 32,
    parameter int KW = 16,
    localparam int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   a_vec,
    input  logic [N*DW-1:0]   b_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*AW-1:0]   out_row,
    output logic [IW-1:0]     out_idx,
    output logic              busy,
    output logic              done
);
    localparam int FW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t         state_reg;
    logic [KW-1:0]  k_len_reg;
    logic [KW-1:0]  k_cnt_reg;
    logic [FW-1:0]  flush_cnt_reg;
    logic [IW-1:0]  idx_reg;
    logic           done_reg;
    logic           hs;
    logic           clear_acc;

    logic signed [DW-1:0] a_pipe [N][N];
    logic signed [DW-1:0] b_pipe [N][N];
    logic [N*AW-1:0]      acc_rows [N];

    assign hs        = in_valid && (state_reg == STREAM);
    assign clear_acc = (state_reg == IDLE) && start;
    assign in_ready  = (state_reg == STREAM);
    assign out_valid = (state_reg == DRAIN);
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign out_idx   = idx_reg;
    assign out_row   = acc_rows[idx_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            k_len_reg     <= '0;
            k_cnt_reg     <= '0;
            flush_cnt_reg <= '0;
            idx_reg       <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        k_len_reg <= k_len;
                        k_cnt_reg <= '0;
                        idx_reg   <= '0;
                        state_reg <= (k_len != '0) ? STREAM : DRAIN;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (k_cnt_reg == k_len_reg - KW'(1)) begin
                            flush_cnt_reg <= '0;
                            state_reg     <= FLUSH;
                        end else begin
                            k_cnt_reg <= k_cnt_reg + KW'(1);
                        end
                    end
                end
                FLUSH: begin
                    // The last vector reaches PE(N-1,N-1) 2N-1 cycles after its handshake.
                    if (flush_cnt_reg == FW'(2 * N - 2)) begin
                        idx_reg   <= '0;
                        state_reg <= DRAIN;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + FW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_reg == IW'(N - 1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Input skew: stage 0 captures the operand (or zero on idle cycles), row/column gi adds gi more stages.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DW-1:0] a_sr [0:gi];
        logic signed [DW-1:0] b_sr [0:gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int d = 0; d <= gi; d++) begin
                    a_sr[d] <= '0;
                    b_sr[d] <= '0;
                end
            end else begin
                a_sr[0] <= hs ? a_vec[gi*DW +: DW] : '0;
                b_sr[0] <= hs ? b_vec[gi*DW +: DW] : '0;
                for (int d = 1; d <= gi; d++) begin
                    a_sr[d] <= a_sr[d-1];
                    b_sr[d] <= b_sr[d-1];
                end
            end
        end

        assign a_pipe[gi][0] = a_sr[gi];
        assign b_pipe[0][gi] = b_sr[gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [2*DW-1:0] prod;
            logic signed [AW-1:0]   acc_reg;
            logic signed [AW-1:0]   acc_next;

            assign prod = a_pipe[gi][gj] * b_pipe[gi][gj];

`ifdef SYSTOLIC_MM_SATURATE_EN
            localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
            localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
            logic signed [AW:0] sum_wide;

            always_comb begin
                sum_wide = (AW+1)'(acc_reg) + (AW+1)'(prod);
                acc_next = sum_wide[AW-1:0];
                if (sum_wide[AW] != sum_wide[AW-1]) begin
                    acc_next = sum_wide[AW] ? ACC_MIN : ACC_MAX;
                end
            end
`else
            assign acc_next = acc_reg + AW'(prod);
`endif

            // Zero operands keep flowing outside STREAM, so accumulators naturally hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (clear_acc) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end

            assign acc_rows[gi][gj*AW +: AW] = acc_reg;

            if (gj < N - 1) begin : g_east
                logic signed [DW-1:0] a_east_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) a_east_reg <= '0;
                    else        a_east_reg <= a_pipe[gi][gj];
                end
                assign a_pipe[gi][gj+1] = a_east_reg;
            end

            if (gi < N - 1) begin : g_south
                logic signed [DW-1:0] b_south_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) b_south_reg <= '0;
                    else        b_south_reg <= b_pipe[gi][gj];
                end
                assign b_pipe[gi+1][gj] = b_south_reg;
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine (N=4, DW=8, AW=16): identity, gaps, backpressure, overflow, empty job, abort.
module tb_systolic_mm_engine;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int KW = 16;
    localparam int IW = 2;
`ifdef SYSTOLIC_MM_SATURATE_EN
    localparam logic [AW-1:0] OVF_VAL = 16'd32767;
`else
    localparam logic [AW-1:0] OVF_VAL = 16'd0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   a_vec;
    logic [N*DW-1:0]   b_vec;
    logic              out_valid;
    logic              out_ready;
    logic [N*AW-1:0]   out_row;
    logic [IW-1:0]     out_idx;
    logic              busy;
    logic              done;

    typedef struct {
        logic [IW-1:0]   idx;
        logic [N*AW-1:0] row;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int jobs_done = 0;
    int busy_err = 0;
    int stall_cnt = 0;
    bit job_active = 0;
    bit bp_mode = 0;

    systolic_mm_engine #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented row is compared against the queue head; popped only on acceptance.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (job_active && !busy && !done) busy_err++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_row", 64'(out_idx), 64'hFFFF);
            end else begin
                check("out_idx", 64'(out_idx), 64'(sb[0].idx));
                check("out_row", out_row, sb[0].row);
                if (out_ready) begin
                    $display("row idx=%0d data=0x%016h", out_idx, out_row);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Backpressure generator: hold out_ready low for 5 cycles while row 1 is presented.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode && out_valid && out_idx == 2'd1 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic set_vectors(input int kind, input int k);
        for (int i = 0; i < N; i++) begin
            if (kind == 1) begin
                a_vec[i*DW +: DW] = 8'h80;
                b_vec[i*DW +: DW] = 8'h80;
            end else begin
                a_vec[i*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
                b_vec[i*DW +: DW] = 8'(4 * k + i + 1);
            end
        end
    endtask

    task automatic send_vector(input int kind, input int k, input bit gap);
        int cnt;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        set_vectors(kind, k);
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // kind: 0 identity, 1 overflow (all -128), 2 empty
    task automatic run_job(input int kind, input int kk, input bit gap, input bit bp, input bit start_in_drain);
        exp_t e;
        int cnt;
        bp_mode = bp;
        stall_cnt = 0;
        for (int i = 0; i < N; i++) begin
            e.idx = IW'(i);
            for (int j = 0; j < N; j++) begin
                e.row[j*AW +: AW] = (kind == 0) ? AW'(4 * i + j + 1) : (kind == 1) ? OVF_VAL : '0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = KW'(kk);
        @(posedge clk);
        #1;
        start = 1'b0;
        job_active = 1'b1;
        for (int k = 0; k < kk; k++) send_vector(kind, k, gap);
        if (start_in_drain) begin
            start = 1'b1;
            k_len = 16'd3;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        cnt = 0;
        while (cnt < 500) begin
            @(negedge clk);
            if (done) break;
            cnt++;
        end
        if (cnt >= 500) check("done_timeout", 64'(done), 64'd1);
        job_active = 1'b0;
        jobs_done++;
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_seen), 64'(jobs_done));
        check("rows_left", 64'(sb.size()), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("busy_during_job", 64'(busy_err), 64'd0);
        $display("job kind=%0d k=%0d gap=%0d bp=%0d complete, stalls=%0d", kind, kk, gap, bp, stall_cnt);
        if (bp) check("stall_cycles", 64'(stall_cnt), 64'd5);
        sb.delete();
        bp_mode = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_out_idx"}, 64'(out_idx), 64'd0);
        check({tag, "_out_row"}, out_row, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        in_valid = 1'b0;
        a_vec = '0;
        b_vec = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_job(0, 4, 1'b0, 1'b0, 1'b0);
        run_job(0, 4, 1'b1, 1'b0, 1'b0);
        run_job(0, 4, 1'b0, 1'b1, 1'b0);
        run_job(1, 4, 1'b0, 1'b0, 1'b0);
        run_job(2, 0, 1'b0, 1'b0, 1'b1);

        // Abort mid-STREAM
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = 16'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_vector(0, 0, 1'b0);
        send_vector(0, 1, 1'b0);
        check("abort_in_stream", 64'(in_ready), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("abort applied at t=%0t", $time);
        check_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(0, 4, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 Parameter N, default 8: array dimension, giving N x N processing elements; legal range 2..32.
REQ-002 Parameter DW, default 8: signed operand width.
REQ-003 Parameter AW, default 32: signed accumulator width; legal only when AW >= 2*DW.
REQ-004 Parameter KW, default 16: width of the reduction-length field.
REQ-005 Port list, one per line (name, direction, width, meaning); the block SHALL implement exactly these ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  job start pulse; sampled only in IDLE.
- k_len  in  KW  reduction length K; sampled with start.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  engine accepts an operand vector.
- a_vec  in  N*DW  column k of A; element i in bits [i*DW +: DW].
- b_vec  in  N*DW  row k of B; element j in bits [j*DW +: DW].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the result row.
- out_row  out  N*AW  C[out_idx][j] in bits [j*AW +: AW].
- out_idx  out  clog2(N)  index of the row currently presented.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-006 The FSM SHALL have four states: IDLE, STREAM, FLUSH and DRAIN.
REQ-007 IDLE: start=1 with k_len!=0 SHALL clear all accumulators, latch k_len and enter STREAM on the next edge.
REQ-008 IDLE: start=1 with k_len=0 SHALL clear all accumulators and enter DRAIN directly.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 in_ready SHALL equal 1 only in STREAM; in_valid SHALL be ignored in all other states.
REQ-011 Each in_valid&&in_ready cycle SHALL inject a_vec/b_vec into the skew registers.
- A row i is delayed i cycles; B column j is delayed j cycles.
REQ-012 A cycle with no handshake SHALL inject zero operands; gaps SHALL NOT change results.
REQ-013 The array SHALL be output-stationary.
- Each PE registers its A input eastward and its B input southward every cycle.
- Each PE adds the sign-extended 2*DW-bit product to its accumulator every cycle.
REQ-014 After the K-th accepted vector, the FSM SHALL enter FLUSH for exactly 2N-1 cycles, then enter DRAIN.
REQ-015 DRAIN: out_valid=1; out_idx SHALL start at 0; out_row SHALL present accumulator row out_idx.
- out_idx SHALL increment on each out_valid&&out_ready.
REQ-016 While out_valid=1 and out_ready=0, out_row and out_idx SHALL hold stable.
REQ-017 Acceptance of row N-1 SHALL pulse done for one cycle and return the FSM to IDLE.
REQ-018 Accumulator contents SHALL hold in IDLE until the next accepted start.
REQ-019 Accumulation SHALL wrap modulo 2^AW (two's complement) unless SATURATE_EN is defined.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE and zero all accumulators, skew registers, PE pipeline registers and counters.
REQ-021 While in reset: in_ready=0, out_valid=0, busy=0, done=0, out_idx=0, out_row=0.
REQ-022 Reset asserted in any state SHALL abort the job; the first start after release SHALL behave as in REQ-007.

Configuration
REQ-023 With macro SYSTOLIC_MM_SATURATE_EN defined, each accumulate SHALL clamp to [-2^(AW-1), 2^(AW-1)-1] instead of wrapping.
REQ-024 Without SYSTOLIC_MM_SATURATE_EN, no saturation logic SHALL be present and REQ-019 wrap behaviour applies.

Verification
REQ-025 Identity: N=4, A=identity, B=[1..16] row-major, K=4, out_ready=1 -> rows {1,2,3,4}..{13,14,15,16}, out_idx 0..3, then done pulse.
REQ-026 Gaps: REQ-025 stimulus with in_valid low on alternate cycles -> identical out_row values; busy held until done.
REQ-027 Backpressure: out_ready=0 for 5 cycles while out_idx=1 -> out_row/out_idx stable, no row lost or duplicated.
REQ-028 Overflow: DW=8, AW=16, all operands -128, K=4 -> every element 0 without macro; 32767 with SYSTOLIC_MM_SATURATE_EN.
REQ-029 Abort: rst_n low mid-STREAM -> busy=0, in_ready=0, out_valid=0 immediately; a following REQ-025 job gives correct results.
REQ-030 Empty job: start with k_len=0 -> N all-zero rows, then done; start pulses during DRAIN ignored.
